// File: rtl/zeroriscy_mult_div_seq.sv
// Sequential 32-bit multiplier/divider: 32 shift-add or restoring shift-subtract
// iterations on a 64-bit accumulator, fixed 33-cycle latency from accept to ready.
package zeroriscy_defines;
  localparam logic [1:0] MD_OP_MULL = 2'b00;
  localparam logic [1:0] MD_OP_MULH = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;
  localparam logic [1:0] MD_OP_REM  = 2'b11;
endpackage

// state | meaning
// IDLE  | waiting for en_i, accept captures operand magnitudes and signs
// CALC  | one iteration per cycle, 32 cycles total
// FIN   | signed result on result_o, ready_o high for this cycle
module zeroriscy_mult_div_seq
  import zeroriscy_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic [31:0] r_a;
  logic [1:0]  r_op;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_b_zero;
  logic [31:0] r_result;
  logic        r_ready;

  logic        w_div_in;
  logic        w_sa_in;
  logic        w_sb_in;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_div_hi;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [63:0] w_div_nxt;
  logic [63:0] w_acc_nxt;
  logic        w_neg;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_res;

  // Division is signed only when both operands are signed
  assign w_div_in = operator_i[1];
  assign w_sa_in  = op_a_i[31] & (w_div_in ? (signed_mode_i == 2'b11) : signed_mode_i[0]);
  assign w_sb_in  = op_b_i[31] & (w_div_in ? (signed_mode_i == 2'b11) : signed_mode_i[1]);
  assign w_a_abs  = w_sa_in ? (32'd0 - op_a_i) : op_a_i;
  assign w_b_abs  = w_sb_in ? (32'd0 - op_b_i) : op_b_i;

  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_nxt = {w_mul_sum, r_acc[31:1]};

  assign w_div_hi  = r_acc[63:31];
  assign w_div_ge  = (w_div_hi >= {1'b0, r_opnd});
  assign w_div_sub = w_div_hi[31:0] - r_opnd;
  assign w_div_nxt = {(w_div_ge ? w_div_sub : w_div_hi[31:0]), r_acc[30:0], w_div_ge};

  assign w_acc_nxt = r_op[1] ? w_div_nxt : w_mul_nxt;

  assign w_neg  = r_sign_a ^ r_sign_b;
  assign w_prod = w_neg ? (64'd0 - w_acc_nxt) : w_acc_nxt;
  assign w_quo  = w_neg ? (32'd0 - w_acc_nxt[31:0]) : w_acc_nxt[31:0];
  assign w_rem  = r_sign_a ? (32'd0 - w_acc_nxt[63:32]) : w_acc_nxt[63:32];

  always_comb begin
    w_res = 32'd0;
    case (r_op)
      MD_OP_MULL: w_res = w_prod[31:0];
      MD_OP_MULH: w_res = w_prod[63:32];
      MD_OP_DIV:  w_res = r_b_zero ? 32'hFFFF_FFFF : w_quo;
      MD_OP_REM:  w_res = r_b_zero ? r_a : w_rem;
      default:    w_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_acc    <= 64'd0;
      r_opnd   <= 32'd0;
      r_a      <= 32'd0;
      r_op     <= 2'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_zero <= 1'b0;
      r_result <= 32'd0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready  <= 1'b0;
          r_result <= 32'd0;
          if (en_i) begin
            r_op     <= operator_i;
            r_a      <= op_a_i;
            r_sign_a <= w_sa_in;
            r_sign_b <= w_sb_in;
            r_b_zero <= (op_b_i == 32'd0);
            r_acc    <= {32'd0, (w_div_in ? w_a_abs : w_b_abs)};
            r_opnd   <= w_div_in ? w_b_abs : w_a_abs;
            r_cnt    <= 5'd31;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (!en_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            if (r_cnt == 5'd0) begin
              r_state  <= S_FIN;
              r_ready  <= 1'b1;
              r_result <= w_res;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
        S_FIN: begin
          r_state  <= S_IDLE;
          r_ready  <= 1'b0;
          r_result <= 32'd0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_ready  <= 1'b0;
          r_result <= 32'd0;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = (r_state != S_IDLE);

endmodule
